// File: rtl/bit_scan_encoder_pkg.sv
// Shared types and helpers for the bit-scan encoder: FSM state encoding and
// a constant-foldable ceil(log2) used to size the index outputs.
package bit_scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_scan_encoder_ffs.sv
// Combinational find-first-set: reports the lowest (or highest, MSB_FIRST=1)
// set bit of i_vec and whether any bit is set at all.
module bit_scan_ffs
  import bit_scan_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter bit          MSB_FIRST = 1'b0,
  localparam int unsigned IDX_W    = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  // Scan towards the preferred end so the last hit wins.
  always_comb begin
    index = '0;
    if (MSB_FIRST) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (i_vec[i]) index = IDX_W'(i);
      end
    end else begin
      for (int unsigned i = WIDTH; i > 0; i--) begin
        if (i_vec[i-1]) index = IDX_W'(i - 1);
      end
    end
  end

  assign any = |i_vec;

endmodule

// File: rtl/bit_scan_encoder.sv
// Captures a multi-hot request vector and emits one beat per set bit over a
// valid/ready stream; an all-zero vector yields a single out_zero beat.
module bit_scan_encoder
  import bit_scan_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter bit          MSB_FIRST = 1'b0,
  localparam int unsigned IDX_W    = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] encoder_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] binary_out,
  output logic             out_last,
  output logic             out_zero
);

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_pend, w_pend_nxt;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic               w_scan;
  logic               w_single;
  logic               w_fire;
  logic               w_accept;

  bit_scan_ffs #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_ffs (
    .i_vec (r_pend),
    .index (w_idx),
    .any   (w_any)
  );

  // Outputs are masked by rst so nothing is presented while reset is held,
  // even before the synchronous clear has taken effect.
  assign w_scan     = (r_state == SCAN) & ~rst;
  assign w_single   = ((r_pend & (r_pend - WIDTH'(1))) == '0);
  assign out_valid  = w_scan;
  assign binary_out = w_scan ? w_idx : '0;
  assign out_last   = w_scan & w_single;
  assign out_zero   = w_scan & ~w_any;

  assign w_fire     = out_valid & out_ready;
  assign in_ready   = enable & ~rst & ((r_state == IDLE) | (w_fire & out_last));
  assign w_accept   = in_valid & in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    if (w_fire) begin
      w_pend_nxt = r_pend & ~(WIDTH'(1) << w_idx);
      if (out_last) w_state_nxt = IDLE;
    end
    if (w_accept) begin
      w_state_nxt = SCAN;
      w_pend_nxt  = encoder_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

endmodule

// File: doc/bit_scan_encoder.md
BIT_SCAN_ENCODER -- requirements
Module: bit_scan_encoder

Interface
REQ-001 Parameter WIDTH, 16, input vector width; SHALL be at least 2.
REQ-002 Parameter MSB_FIRST, 0, scan order: 0 = lowest set bit first, 1 = highest set bit first.
REQ-003 Localparam IDX_W, clog2(WIDTH), index width; SHALL NOT be overridable.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset; SHALL be synchronous and active-high.
REQ-006 enable  input  1  SHALL gate acceptance of new vectors.
REQ-007 in_valid  input  1  encoder_in is valid.
REQ-008 in_ready  output  1  block accepts encoder_in this cycle.
REQ-009 encoder_in  input  WIDTH  request vector, multi-hot allowed.
REQ-010 out_valid  output  1  binary_out, out_last and out_zero are valid.
REQ-011 out_ready  input  1  consumer accepts the current beat.
REQ-012 binary_out  output  IDX_W  index of the set bit reported in this beat.
REQ-013 out_last  output  1  final beat for the captured vector.
REQ-014 out_zero  output  1  captured vector was all zeros.

Function
REQ-015 States SHALL be IDLE (no vector held) and SCAN (pending vector held, out_valid=1).
REQ-016 Input accept occurs when in_valid & in_ready; the vector SHALL be captured into the pending register.
REQ-017 in_ready SHALL equal enable & (state==IDLE | (out_valid & out_ready & out_last)), allowing back-to-back vectors with no bubble.
REQ-018 The first beat SHALL appear on out_valid the cycle after accept, giving 1-cycle latency.
REQ-019 Each beat SHALL report the lowest set pending bit (MSB_FIRST=0) or the highest (MSB_FIRST=1).
REQ-020 On out_valid & out_ready, the reported bit SHALL be cleared from the pending register.
REQ-021 out_last SHALL be 1 when exactly one bit remains pending.
REQ-022 A captured vector of all zeros SHALL produce exactly one beat with binary_out=0, out_zero=1 and out_last=1.
REQ-023 out_zero SHALL be 0 on every beat of a non-zero vector.
REQ-024 While out_valid=1 and out_ready=0, binary_out, out_last and out_zero SHALL hold stable.
REQ-025 A last-beat handshake without a new accept SHALL move the state from SCAN to IDLE.
REQ-026 A last-beat handshake with a simultaneous accept SHALL remain in SCAN with the new vector loaded.
REQ-027 Deasserting enable SHALL block new accepts only; an in-progress scan SHALL complete.
REQ-028 A vector with N set bits SHALL yield exactly N beats, with N <= WIDTH.
REQ-029 No beat SHALL be dropped or duplicated under any out_ready pattern.
REQ-030 An all-ones vector SHALL produce WIDTH beats, indices 0..WIDTH-1 in order, or reversed when MSB_FIRST=1.

Reset
REQ-031 While rst=1, the block SHALL enter IDLE, clear the pending register, and drive out_valid=0, binary_out=0, out_last=0 and out_zero=0.
REQ-032 While rst=1, in_ready SHALL be 0; after release, in_ready SHALL equal enable.
REQ-033 Reset during SCAN SHALL discard the remaining bits; no beat SHALL be emitted in the cycle after reset.

Structure
REQ-034 Package bit_scan_pkg SHALL hold the state enum (IDLE, SCAN) and the clog2 helper function.
REQ-035 Find-first-set logic SHALL be a separate combinational sub-module, bit_scan_ffs, parametrised by WIDTH and MSB_FIRST, with outputs index and any.
REQ-036 The top level SHALL contain only the state register, the pending register and the handshake logic.

Verification (WIDTH=16)
REQ-037 Input 16'h0002, out_ready=1 -> single beat: binary_out=1, out_last=1, out_zero=0, one cycle after accept.
REQ-038 Input 16'h8421 -> beats 0, 5, 10, 15 with out_last on 15; with MSB_FIRST=1 -> beats 15, 10, 5, 0.
REQ-039 Input 16'h0000 -> one beat: binary_out=0, out_zero=1, out_last=1; then return to IDLE.
REQ-040 Input 16'h00F0 with out_ready low for 3 cycles at the second beat -> binary_out held at 5 throughout the stall, then 6 and 7 follow.
REQ-041 Input 16'h0001 then 16'h0003 presented continuously -> second vector accepted on the out_last cycle; beats 0, 0, 1 on consecutive cycles with no bubble.
REQ-042 Input 16'hFFFF, rst pulsed after the 4th beat -> out_valid=0 the next cycle, in_ready=enable, and the next vector 16'h0004 yields a single beat with binary_out=2.
